host_uart_link: RTL

Host-side end of the MIPS debug UART link. It turns a program image, presented as 32-bit words, into the byte frame the target loader expects, and drives it out on TX at 8N1. It also reassembles the 32-bit result words the target returns on RX. The block sits in the bench/host FPGA and shares the 16x-oversampled baud tick `s_tick` generated by the existing baud-rate generator.

---
 rtl/uart_link_pkg.sv | 41 ++++
 rtl/uart_byte_tx.sv | 108 ++++++++++
 rtl/host_uart_link.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_link_pkg
// Description : Shared constants and state encodings for the host-side
//               MIPS debug UART link (TX frame builder, serializer, RX path).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_link_pkg;

  localparam logic [7:0] HDR_BYTE   = 8'hA5;  // loader frame header
  localparam int         OVERSAMPLE = 16;     // s_tick pulses per bit
  localparam int         MID_SAMPLE = 7;      // start-bit re-check point

  typedef enum logic [3:0] {
    CTL_IDLE      = 4'd0,
    CTL_HDR       = 4'd1,
    CTL_CNT       = 4'd2,
    CTL_WAIT_WORD = 4'd3,
    CTL_SEND_B3   = 4'd4,
    CTL_SEND_B2   = 4'd5,
    CTL_SEND_B1   = 4'd6,
    CTL_SEND_B0   = 4'd7,
    CTL_DONE      = 4'd8
  } ctl_state_e;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_tx
// Description : 8N1 byte serializer driven by a 16x oversampled tick.
//               start : one-cycle launch, din captured with it
//               din   : character to send (LSB first)
//               done  : one-cycle pulse as the stop bit completes
//               tx    : registered serial output, idles high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_tx
  import uart_link_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            start,
  input  logic [DBIT-1:0] din,
  output logic            done,
  output logic            tx
);

  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  ser_state_e      state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SER_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    tx_d    = tx_q;
    done    = 1'b0;
    unique case (state_q)
      SER_IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          state_d = SER_START;
          s_d     = '0;
          b_d     = din;
          tx_d    = 1'b0;
        end
      end
      SER_START: if (s_tick) begin
        if (s_q == SW'(OVERSAMPLE - 1)) begin
          state_d = SER_DATA;
          s_d     = '0;
          n_d     = '0;
          tx_d    = b_q[0];
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      SER_DATA: if (s_tick) begin
        if (s_q == SW'(OVERSAMPLE - 1)) begin
          s_d = '0;
          b_d = b_q >> 1;
          if (n_q == NW'(DBIT - 1)) begin
            state_d = SER_STOP;
            tx_d    = 1'b1;
          end else begin
            n_d  = n_q + 1'b1;
            tx_d = b_d[0];
          end
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      SER_STOP: if (s_tick) begin
        if (s_q == SW'(SB_TICK - 1)) begin
          state_d = SER_IDLE;
          done    = 1'b1;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  assign tx = tx_q;

endmodule
`default_nettype wire

// File: rtl/host_uart_link.sv
`default_nettype none
// ============================================================================
// Module      : host_uart_link
// Description : Host end of the MIPS debug UART link.
//               TX: cmd_start/word_count start a load frame
//                   (A5, count, words MSB first); words enter through the
//                   word_in/word_valid/word_ready handshake; busy spans it.
//               RX: RX is deserialized (8N1); good bytes are packed MSB
//                   first into result/result_valid; bad stop bits pulse
//                   frame_error. A long inter-byte gap drops a partial word.
// Revision    : 1.0 - initial release
// ============================================================================
module host_uart_link
  import uart_link_pkg::*;
#(
  parameter int DBIT      = 8,
  parameter int SB_TICK   = 16,
  parameter int GAP_TICKS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_tick,
  input  logic        cmd_start,
  input  logic [7:0]  word_count,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        busy,
  input  logic        RX,
  output logic        TX,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        frame_error
);

  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int GW = $clog2(GAP_TICKS);

  // -------------------------------------------------------------- TX control
  ctl_state_e  ctl_q, ctl_d;
  logic [7:0]  count_q, count_d;
  logic [31:0] word_q, word_d;
  logic        launched_q, launched_d;  // current byte already handed over
  logic        ser_start, ser_done;
  logic [7:0]  ser_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_q      <= CTL_IDLE;
      count_q    <= '0;
      word_q     <= '0;
      launched_q <= 1'b0;
    end else begin
      ctl_q      <= ctl_d;
      count_q    <= count_d;
      word_q     <= word_d;
      launched_q <= launched_d;
    end
  end

  always_comb begin
    ctl_d      = ctl_q;
    count_d    = count_q;
    word_d     = word_q;
    launched_d = launched_q;
    word_ready = 1'b0;
    ser_start  = 1'b0;
    ser_byte   = HDR_BYTE;
    unique case (ctl_q)
      CTL_IDLE: if (cmd_start && word_count != 8'd0) begin
        count_d = word_count;
        ctl_d   = CTL_HDR;
      end
      CTL_HDR: begin
        ser_start = !launched_q;
        if (ser_done) ctl_d = CTL_CNT;
      end
      CTL_CNT: begin
        ser_byte  = count_q;
        ser_start = !launched_q;
        if (ser_done) ctl_d = CTL_WAIT_WORD;
      end
      CTL_WAIT_WORD: begin
        word_ready = 1'b1;
        if (word_valid) begin
          word_d = word_in;
          ctl_d  = CTL_SEND_B3;
        end
      end
      CTL_SEND_B3: begin
        ser_byte  = word_q[31:24];
        ser_start = !launched_q;
        if (ser_done) ctl_d = CTL_SEND_B2;
      end
      CTL_SEND_B2: begin
        ser_byte  = word_q[23:16];
        ser_start = !launched_q;
        if (ser_done) ctl_d = CTL_SEND_B1;
      end
      CTL_SEND_B1: begin
        ser_byte  = word_q[15:8];
        ser_start = !launched_q;
        if (ser_done) ctl_d = CTL_SEND_B0;
      end
      CTL_SEND_B0: begin
        ser_byte  = word_q[7:0];
        ser_start = !launched_q;
        if (ser_done) begin
          count_d = count_q - 8'd1;
          ctl_d   = (count_q == 8'd1) ? CTL_DONE : CTL_WAIT_WORD;
        end
      end
      CTL_DONE: ctl_d = CTL_IDLE;
      default:  ctl_d = CTL_IDLE;
    endcase
    if (ser_start)     launched_d = 1'b1;
    else if (ser_done) launched_d = 1'b0;
  end

  assign busy = (ctl_q != CTL_IDLE);

  uart_byte_tx #(
    .DBIT    (DBIT),
    .SB_TICK (SB_TICK)
  ) u_byte_tx (
    .clk    (clk),
    .reset  (reset),
    .s_tick (s_tick),
    .start  (ser_start),
    .din    (DBIT'(ser_byte)),
    .done   (ser_done),
    .tx     (TX)
  );

  // -------------------------------------------------------------- RX path
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e       rx_q, rx_d;
  logic [SW-1:0]   rs_q, rs_d;
  logic [NW-1:0]   rn_q, rn_d;
  logic [DBIT-1:0] rb_q, rb_d;
  logic            good_byte, bad_byte;

  logic [31:0]     acc_q, acc_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [31:0]     result_q, result_d;
  logic            rv_q, rv_d;
  logic            fe_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_q      <= RX_IDLE;
      rs_q      <= '0;
      rn_q      <= '0;
      rb_q      <= '0;
      acc_q     <= '0;
      bcnt_q    <= '0;
      gap_q     <= '0;
      result_q  <= '0;
      rv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      rx_s1_q   <= RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_q      <= rx_d;
      rs_q      <= rs_d;
      rn_q      <= rn_d;
      rb_q      <= rb_d;
      acc_q     <= acc_d;
      bcnt_q    <= bcnt_d;
      gap_q     <= gap_d;
      result_q  <= result_d;
      rv_q      <= rv_d;
      fe_q      <= bad_byte;
    end
  end

  always_comb begin
    rx_d      = rx_q;
    rs_d      = rs_q;
    rn_d      = rn_q;
    rb_d      = rb_q;
    good_byte = 1'b0;
    bad_byte  = 1'b0;
    unique case (rx_q)
      // Edge rather than level, so a line held low after a bad stop bit
      // does not retrigger a character.
      RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_d = RX_START;
        rs_d = '0;
      end
      RX_START: if (s_tick) begin
        if (rs_q == SW'(MID_SAMPLE)) begin
          rs_d = '0;
          rn_d = '0;
          rx_d = rx_s2_q ? RX_IDLE : RX_DATA;  // high here means a glitch
        end else begin
          rs_d = rs_q + 1'b1;
        end
      end
      RX_DATA: if (s_tick) begin
        if (rs_q == SW'(OVERSAMPLE - 1)) begin
          rs_d = '0;
          rb_d = {rx_s2_q, rb_q[DBIT-1:1]};
          if (rn_q == NW'(DBIT - 1)) rx_d = RX_STOP;
          else                       rn_d = rn_q + 1'b1;
        end else begin
          rs_d = rs_q + 1'b1;
        end
      end
      RX_STOP: if (s_tick) begin
        if (rs_q == SW'(SB_TICK - 1)) begin
          rx_d      = RX_IDLE;
          good_byte = rx_s2_q;
          bad_byte  = !rx_s2_q;
        end else begin
          rs_d = rs_q + 1'b1;
        end
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  // Word reassembly with inter-byte gap timeout.
  always_comb begin
    acc_d    = acc_q;
    bcnt_d   = bcnt_q;
    gap_d    = gap_q;
    result_d = result_q;
    rv_d     = 1'b0;
    if (good_byte) begin
      acc_d  = {acc_q[23:0], 8'(rb_q)};
      bcnt_d = bcnt_q + 1'b1;
      gap_d  = '0;
      if (bcnt_q == 2'd3) begin
        result_d = {acc_q[23:0], 8'(rb_q)};
        rv_d     = 1'b1;
      end
    end else if (bcnt_q != 2'd0 && s_tick) begin
      if (gap_q == GW'(GAP_TICKS - 1)) begin
        acc_d  = '0;
        bcnt_d = '0;
        gap_d  = '0;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  assign result       = result_q;
  assign result_valid = rv_q;
  assign frame_error  = fe_q;

endmodule
`default_nettype wire
